regfile_mp: RTL and testbench



---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_read_port.sv | 66 ++++++
 rtl/regfile_mp.sv | 99 +++++++++
 tb/tb_regfile_mp.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Optional feature macro: REGFILE_BYPASS_EN (same-edge write-to-read forwarding).
package regfile_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_NUM_READ   = 2;

  // Register 0 is hardwired to zero and can never be reserved.
  localparam int ZERO_REG = 0;

  // Number of architectural registers addressable by a select of the given width.
  function automatic int regfile_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port of the register file: select decode, optional
// write-to-read forwarding and the output registers.
// Optional feature macro: REGFILE_BYPASS_EN.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = regfile_depth(DEF_ADDR_WIDTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_sel,
  input  logic [DATA_WIDTH-1:0] regs [DEPTH],
  input  logic [DEPTH-1:0]      busy_now,
  input  logic [DEPTH-1:0]      busy_next,
  input  logic                  write0,
  input  logic [ADDR_WIDTH-1:0] write_sel0,
  input  logic [DATA_WIDTH-1:0] write_data0,
  input  logic                  write1,
  input  logic [ADDR_WIDTH-1:0] write_sel1,
  input  logic [DATA_WIDTH-1:0] write_data1,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_busy
);

  logic [DATA_WIDTH-1:0] data_p0;
  logic                  busy_p0;

`ifdef REGFILE_BYPASS_EN
  // Select the array word, overridden by a matching same-edge write (port 1 first).
  always_comb begin
    data_p0 = regs[read_sel];
    busy_p0 = busy_next[read_sel];
    if (write1 && (write_sel1 != '0) && (write_sel1 == read_sel)) begin
      data_p0 = write_data1;
    end else if (write0 && (write_sel0 != '0) && (write_sel0 == read_sel)) begin
      data_p0 = write_data0;
    end
  end
`else
  // Without forwarding the write-side and post-edge scoreboard inputs are not needed.
  logic unused_bypass_inputs;
  assign unused_bypass_inputs = ^{busy_next, write0, write_sel0, write_data0,
                                  write1, write_sel1, write_data1};

  // Select the pre-edge array word and pre-edge busy bit.
  always_comb begin
    data_p0 = regs[read_sel];
    busy_p0 = busy_now[read_sel];
  end
`endif

  // ---- stage p0 -> registered read outputs ----
  // Capture the selected word and busy flag on every edge; reset clears both.
  always_ff @(posedge clock) begin
    if (reset) begin
      read_data <= '0;
      read_busy <= 1'b0;
    end else begin
      read_data <= data_p0;
      read_busy <= busy_p0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_READ registered read ports, two prioritised
// write ports (port 1 wins), hardwired-zero register 0 and a busy scoreboard
// used by issue to stall on pending writebacks.
// Optional feature macro: REGFILE_BYPASS_EN (same-edge write-to-read forwarding).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_READ   = DEF_NUM_READ
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] read_sel,
  output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
  output logic [NUM_READ-1:0]            read_busy,
  input  logic                           write0,
  input  logic [ADDR_WIDTH-1:0]          write_sel0,
  input  logic [DATA_WIDTH-1:0]          write_data0,
  input  logic                           write1,
  input  logic [ADDR_WIDTH-1:0]          write_sel1,
  input  logic [DATA_WIDTH-1:0]          write_data1,
  input  logic                           reserve,
  input  logic [ADDR_WIDTH-1:0]          reserve_sel,
  output logic [(2**ADDR_WIDTH)-1:0]     busy_vec
);

  localparam int DEPTH = regfile_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy_q;
  logic [DEPTH-1:0]      busy_next;

  // Register array: port 1 is applied last so it wins on an address clash; r0 is never written.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (write0 && (write_sel0 != '0)) begin
        regs[write_sel0] <= write_data0;
      end
      if (write1 && (write_sel1 != '0)) begin
        regs[write_sel1] <= write_data1;
      end
    end
  end

  // Next scoreboard: writebacks clear, a reserve sets afterwards so a new producer wins.
  always_comb begin
    busy_next = busy_q;
    if (write0) begin
      busy_next[write_sel0] = 1'b0;
    end
    if (write1) begin
      busy_next[write_sel1] = 1'b0;
    end
    if (reserve) begin
      busy_next[reserve_sel] = 1'b1;
    end
    busy_next[ZERO_REG] = 1'b0;
  end

  // Scoreboard register; reset drops every pending producer.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_next;
    end
  end

  assign busy_vec = busy_q;

  for (genvar k = 0; k < NUM_READ; k++) begin : g_read
    regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
    ) u_port (
      .clock       (clock),
      .reset       (reset),
      .read_sel    (read_sel[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .regs        (regs),
      .busy_now    (busy_q),
      .busy_next   (busy_next),
      .write0      (write0),
      .write_sel0  (write_sel0),
      .write_data0 (write_data0),
      .write1      (write1),
      .write_sel1  (write_sel1),
      .write_data1 (write_data1),
      .read_data   (read_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .read_busy   (read_busy[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (default parameters, two read ports).
// Expected outputs are queued when a step is driven and compared after its edge.
module tb_regfile_mp;

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  read_sel;
  logic [63:0] read_data;
  logic [1:0]  read_busy;
  logic        write0, write1, reserve;
  logic [4:0]  write_sel0, write_sel1, reserve_sel;
  logic [31:0] write_data0, write_data1;
  logic [31:0] busy_vec;

  int checks   = 0;
  int failures = 0;

  regfile_mp dut (
    .clock       (clock),
    .reset       (reset),
    .read_sel    (read_sel),
    .read_data   (read_data),
    .read_busy   (read_busy),
    .write0      (write0),
    .write_sel0  (write_sel0),
    .write_data0 (write_data0),
    .write1      (write1),
    .write_sel1  (write_sel1),
    .write_data1 (write_data1),
    .reserve     (reserve),
    .reserve_sel (reserve_sel),
    .busy_vec    (busy_vec)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        w0;
    logic [4:0]  ws0;
    logic [31:0] wd0;
    logic        w1;
    logic [4:0]  ws1;
    logic [31:0] wd1;
    logic        rsv;
    logic [4:0]  rs;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        eb0;
    logic        eb1;
    logic [31:0] ebv;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        eb0;
    logic        eb1;
    logic [31:0] ebv;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic w0, input logic [4:0] ws0,
                              input logic [31:0] wd0, input logic w1, input logic [4:0] ws1,
                              input logic [31:0] wd1, input logic rsv, input logic [4:0] rs,
                              input logic [4:0] r0, input logic [4:0] r1,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic eb0, input logic eb1, input logic [31:0] ebv);
    vec_t v;
    v.rst = rst; v.w0 = w0; v.ws0 = ws0; v.wd0 = wd0;
    v.w1 = w1; v.ws1 = ws1; v.wd1 = wd1; v.rsv = rsv; v.rs = rs;
    v.r0 = r0; v.r1 = r1; v.e0 = e0; v.e1 = e1; v.eb0 = eb0; v.eb1 = eb1; v.ebv = ebv;
    return v;
  endfunction

  task automatic cmp(input string name, input string what, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s %s: got 0x%08h expected 0x%08h", name, what, act, req);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard: no expected entry for output");
      return;
    end
    e = exp_q.pop_front();
    cmp(e.name, "rd0_data", read_data[31:0], e.e0);
    cmp(e.name, "rd1_data", read_data[63:32], e.e1);
    cmp(e.name, "rd0_busy", {31'b0, read_busy[0]}, {31'b0, e.eb0});
    cmp(e.name, "rd1_busy", {31'b0, read_busy[1]}, {31'b0, e.eb1});
    cmp(e.name, "busy_vec", busy_vec, e.ebv);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    exp_t e;
    reset = v.rst;
    write0 = v.w0; write_sel0 = v.ws0; write_data0 = v.wd0;
    write1 = v.w1; write_sel1 = v.ws1; write_data1 = v.wd1;
    reserve = v.rsv; reserve_sel = v.rs;
    read_sel = {v.r1, v.r0};
    e.name = name; e.e0 = v.e0; e.e1 = v.e1; e.eb0 = v.eb0; e.eb1 = v.eb1; e.ebv = v.ebv;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    check_out();
  endtask

  localparam logic B = 1'b1;
  localparam logic O = 1'b0;

  initial begin
    // Reset held for two edges; outputs must be zero after each.
    run_vec("reset_a", mk(B, B, 5'd2, 32'h1, O, 5'd0, 32'h0, B, 5'd3, 5'd2, 5'd3, 0, 0, O, O, 0));
    run_vec("reset_b", mk(B, O, 5'd0, 32'h0, O, 5'd0, 32'h0, O, 5'd0, 5'd2, 5'd3, 0, 0, O, O, 0));

    // Every register reads zero and idle after reset.
    for (int i = 0; i < 32; i++) begin
      run_vec($sformatf("post_reset_r%0d", i),
              mk(O, O, 5'd0, 32'h0, O, 5'd0, 32'h0, O, 5'd0, 5'(i), 5'(31 - i), 0, 0, O, O, 0));
    end

    // Table of steps whose results do not depend on forwarding.
    tbl.push_back(mk(O, B, 5'd1, 32'h2, O, 5'd0, 32'h0, O, 5'd0, 5'd0, 5'd0, 0, 0, O, O, 0));
    tbl.push_back(mk(O, B, 5'd3, 32'h5, O, 5'd0, 32'h0, O, 5'd0, 5'd1, 5'd0, 32'h2, 0, O, O, 0));
    tbl.push_back(mk(O, O, 5'd0, 32'h0, B, 5'd7, 32'h9, O, 5'd0, 5'd3, 5'd1, 32'h5, 32'h2, O, O, 0));
    tbl.push_back(mk(O, B, 5'd0, 32'h7, O, 5'd0, 32'h0, O, 5'd0, 5'd7, 5'd0, 32'h9, 0, O, O, 0));
    tbl.push_back(mk(O, B, 5'd5, 32'hA, B, 5'd5, 32'hB, O, 5'd0, 5'd0, 5'd7, 0, 32'h9, O, O, 0));
    tbl.push_back(mk(O, O, 5'd0, 32'h0, O, 5'd0, 32'h0, O, 5'd0, 5'd5, 5'd0, 32'hB, 0, O, O, 0));
    tbl.push_back(mk(O, O, 5'd0, 32'h0, O, 5'd0, 32'h0, B, 5'd9, 5'd1, 5'd3, 32'h2, 32'h5, O, O, 32'h200));
    tbl.push_back(mk(O, O, 5'd0, 32'h0, O, 5'd0, 32'h0, O, 5'd0, 5'd9, 5'd1, 0, 32'h2, B, O, 32'h200));
    tbl.push_back(mk(O, B, 5'd9, 32'h3, O, 5'd0, 32'h0, O, 5'd0, 5'd3, 5'd7, 32'h5, 32'h9, O, O, 0));
    tbl.push_back(mk(O, O, 5'd0, 32'h0, O, 5'd0, 32'h0, O, 5'd0, 5'd9, 5'd9, 32'h3, 32'h3, O, O, 0));
    tbl.push_back(mk(O, O, 5'd0, 32'h0, O, 5'd0, 32'h0, B, 5'd4, 5'd0, 5'd9, 0, 32'h3, O, O, 32'h10));
    tbl.push_back(mk(O, O, 5'd0, 32'h0, O, 5'd0, 32'h0, B, 5'd6, 5'd4, 5'd0, 0, 0, B, O, 32'h50));
    tbl.push_back(mk(O, O, 5'd0, 32'h0, B, 5'd0, 32'h55, B, 5'd0, 5'd6, 5'd4, 0, 0, B, B, 32'h50));
    tbl.push_back(mk(O, O, 5'd0, 32'h0, O, 5'd0, 32'h0, O, 5'd0, 5'd0, 5'd6, 0, 0, O, B, 32'h50));
    for (int i = 0; i < tbl.size(); i++) begin
      run_vec($sformatf("table_%0d", i), tbl[i]);
    end

    // Same-edge write and read of r5: old value, or forwarded value with bypass.
`ifdef REGFILE_BYPASS_EN
    run_vec("same_edge_rw", mk(O, B, 5'd5, 32'hC, O, 5'd0, 32'h0, O, 5'd0, 5'd5, 5'd5, 32'hC, 32'hC, O, O, 32'h50));
`else
    run_vec("same_edge_rw", mk(O, B, 5'd5, 32'hC, O, 5'd0, 32'h0, O, 5'd0, 5'd5, 5'd5, 32'hB, 32'hB, O, O, 32'h50));
`endif
    run_vec("same_edge_rw_next", mk(O, O, 5'd0, 32'h0, O, 5'd0, 32'h0, O, 5'd0, 5'd5, 5'd5, 32'hC, 32'hC, O, O, 32'h50));

    // Both write ports on r5 with a same-edge read: port 1 data is the one forwarded/stored.
`ifdef REGFILE_BYPASS_EN
    run_vec("prio_rw", mk(O, B, 5'd5, 32'h11, B, 5'd5, 32'h22, O, 5'd0, 5'd5, 5'd3, 32'h22, 32'h5, O, O, 32'h50));
`else
    run_vec("prio_rw", mk(O, B, 5'd5, 32'h11, B, 5'd5, 32'h22, O, 5'd0, 5'd5, 5'd3, 32'hC, 32'h5, O, O, 32'h50));
`endif
    run_vec("prio_rw_next", mk(O, O, 5'd0, 32'h0, O, 5'd0, 32'h0, O, 5'd0, 5'd5, 5'd0, 32'h22, 0, O, O, 32'h50));

    // Reserve r9, then reserve and write r9 on the same edge: busy stays, data lands.
    run_vec("rsv_r9", mk(O, O, 5'd0, 32'h0, O, 5'd0, 32'h0, B, 5'd9, 5'd0, 5'd0, 0, 0, O, O, 32'h250));
`ifdef REGFILE_BYPASS_EN
    run_vec("rsv_wr_r9", mk(O, B, 5'd9, 32'h44, O, 5'd0, 32'h0, B, 5'd9, 5'd9, 5'd1, 32'h44, 32'h2, B, O, 32'h250));
`else
    run_vec("rsv_wr_r9", mk(O, B, 5'd9, 32'h44, O, 5'd0, 32'h0, B, 5'd9, 5'd9, 5'd1, 32'h3, 32'h2, B, O, 32'h250));
`endif
    run_vec("rsv_wr_r9_next", mk(O, O, 5'd0, 32'h0, O, 5'd0, 32'h0, O, 5'd0, 5'd9, 5'd0, 32'h44, 0, B, O, 32'h250));
    // Writeback on port 1 alone clears r9's busy bit.
`ifdef REGFILE_BYPASS_EN
    run_vec("wb1_r9", mk(O, O, 5'd0, 32'h0, B, 5'd9, 32'h66, O, 5'd0, 5'd9, 5'd0, 32'h66, 0, O, O, 32'h50));
`else
    run_vec("wb1_r9", mk(O, O, 5'd0, 32'h0, B, 5'd9, 32'h66, O, 5'd0, 5'd9, 5'd0, 32'h44, 0, B, O, 32'h50));
`endif
    run_vec("wb0_r4", mk(O, B, 5'd4, 32'h77, O, 5'd0, 32'h0, O, 5'd0, 5'd9, 5'd6, 32'h66, 0, O, B, 32'h40));

    // Mid-stream reset discards busy bits, data and the write/reserve in that cycle.
    run_vec("mid_reset", mk(B, B, 5'd2, 32'h99, O, 5'd0, 32'h0, B, 5'd8, 5'd6, 5'd9, 0, 0, O, O, 0));
    run_vec("after_reset_a", mk(O, O, 5'd0, 32'h0, O, 5'd0, 32'h0, O, 5'd0, 5'd2, 5'd6, 0, 0, O, O, 0));
    run_vec("after_reset_b", mk(O, O, 5'd0, 32'h0, O, 5'd0, 32'h0, O, 5'd0, 5'd9, 5'd4, 0, 0, O, O, 0));

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
